image_stream_arbiter: RTL and testbench
=======================================

// Module: image_stream_arbiter
// PURPOSE
//  Shares one AXI-Stream sink between N_SOURCES image streams, e.g. several bin2stream-style
//  feeders driving one accelerator input. Grants are round-robin and image-atomic: once a
//  source is granted, exactly WORDS_PER_IMAGE words pass before any other source is considered.
//  Words are never interleaved between images; m_tdest tags the owning source.
// PARAMETERS
//  N_SOURCES        2   number of input streams (>=1)
//  WORDS_PER_IMAGE  4   words per image, the grant granularity (>=1)
//  BITS_PER_WORD    8   payload bits per word; DW = 8*((BITS_PER_WORD+7)/8)
// PORTS
//  ap_clk     in   1             clock
//  ap_rst_n   in   1             asynchronous reset, active-low
//  s_tdata    in   N_SOURCES*DW  source i occupies bits [i*DW+:DW]
//  s_tvalid   in   N_SOURCES     per-source valid
//  s_tready   out  N_SOURCES     per-source ready
//  m_tdata    out  DW            granted source payload
//  m_tvalid   out  1             output valid
//  m_tready   in   1             sink ready
//  m_tdest    out  SW            granted source index; SW = max(1,$clog2(N_SOURCES))
// BEHAVIOUR
//  - FSM IDLE/STREAM. Reset: IDLE, Grant=0, Cnt=0, Last=N_SOURCES-1, so source 0 wins first.
//  - Reset outputs: m_tvalid=0, s_tready=0, m_tdest=0. m_tdata is don't-care.
//  - IDLE: pick the first i with s_tvalid[i], searching Last+1, Last+2, ... with wrap-around.
//    If one is found: Grant<=i, Last<=i, Cnt<=0, next state STREAM. Otherwise stay in IDLE.
//    Arbitration takes 1 cycle, so there is one bubble cycle between consecutive images.
//  - STREAM: zero-latency combinational pass-through:
//    m_tvalid=s_tvalid[Grant], m_tdata=s_tdata[Grant], s_tready[Grant]=m_tready.
//    All other s_tready are 0; m_tdest=Grant.
//  - On each handshake (m_tvalid&&m_tready): if Cnt==WORDS_PER_IMAGE-1, Cnt<=0 and go to IDLE;
//    otherwise Cnt<=Cnt+1. Cnt width $clog2(WORDS_PER_IMAGE+1).
//  - A granted source dropping tvalid mid-image stalls the output (m_tvalid=0). The grant is
//    held, with no timeout and no preemption.
//  - m_tready low holds the word. m_tdata/m_tdest stay stable while m_tvalid=1 because the
//    source obeys AXIS.
//  - In IDLE, m_tvalid=0 and all s_tready are 0, even if a source is valid.
//  - N_SOURCES==1: the FSM still runs; every image is followed by a 1-cycle IDLE bubble.
//  - Reset mid-image: immediate return to IDLE. The partial image is abandoned, and realigning
//    the sources is their own responsibility.
// CONFIGURATION
//  IMAGE_STREAM_ARBITER_TLAST_EN defined:
//    adds output m_tlast (1 bit) = (state==STREAM && Cnt==WORDS_PER_IMAGE-1); reset value 0.
//  Not defined: no m_tlast port; behaviour otherwise identical.
// STRUCTURE
//  Package image_arb_pkg:
//    state enum {IDLE,STREAM};
//    function src_width(n) returning max(1,$clog2(n)).
//  Sub-module image_rr_pick: combinational round-robin picker,
//    inputs req[N] and last[SW], outputs found and idx[SW].
//  Top: FSM, Cnt/Grant/Last registers, output muxing.
// TESTING
//  1. Only s0 valid, WORDS_PER_IMAGE=4, m_tready=1 -> words d0..d3 out on 4 consecutive cycles,
//     m_tdest=0, then 1 IDLE cycle.
//  2. s0 and s1 always valid -> image order s0,s1,s0,s1; each image exactly 4 words,
//     no interleaving.
//  3. m_tready toggled 1,0,1,0 during an image -> m_tdata held while stalled; 4 handshakes
//     then IDLE.
//  4. Granted s1 drops tvalid after word 2 for 3 cycles while s0 is valid -> m_tvalid=0,
//     grant stays 1, s_tready[0]=0; resumes with word 3.
//  5. ap_rst_n asserted after word 1 -> m_tvalid=0 and s_tready=0 immediately. After release,
//     s0 is granted first with Cnt=0.
//  6. TLAST_EN build, WORDS_PER_IMAGE=1 -> m_tlast=1 on every word; scoreboard checks
//     m_tdest against the source.

Source files
------------

// File: rtl/image_arb_pkg.sv
// Shared types and helpers for the image stream arbiter.
//   state_e    : arbiter FSM states (IDLE = arbitrating, STREAM = passing an image)
//   src_width  : width of a source index, never less than one bit
package image_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int src_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/image_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting just after the previously granted index, wrapping around,
// and reports the first requester found.
//   req   in  N   request vector (one bit per source)
//   last  in  SW  index granted last time; the search starts at last+1
//   found out 1   at least one request is set
//   idx   out SW  chosen source (0 when nothing is found)
module image_rr_pick #(
    parameter int N  = 2,
    parameter int SW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic          found,
    output logic [SW-1:0] idx
);

    // Walk the distances from farthest to nearest so the nearest requester
    // after 'last' is the one left standing in idx.
    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = N; k >= 1; k--) begin
            c = (int'(last) + k) % N;
            if (req[c]) begin
                found = 1'b1;
                idx   = SW'(c);
            end
        end
    end

endmodule

// File: rtl/image_stream_arbiter.sv
// Image-atomic round-robin arbiter sharing one AXI-Stream sink between
// N_SOURCES image streams. Once a source is granted, exactly WORDS_PER_IMAGE
// words pass before another source is considered; m_tdest tags the owner.
// Ports:
//   ap_clk, ap_rst_n  clock, asynchronous active-low reset
//   s_tdata/s_tvalid  per-source payload (source i at [i*DW +: DW]) and valid
//   s_tready          per-source ready (only the granted source can see ready)
//   m_tdata/m_tvalid  sink payload and valid
//   m_tready          sink ready
//   m_tdest           granted source index
//   m_tlast           last word of an image (only with IMAGE_STREAM_ARBITER_TLAST_EN)
// Handshake: a word moves on a cycle where valid && ready are both high; in
// STREAM the granted source is wired straight through to the sink, so valid,
// ready and data follow AXIS rules end to end with zero added latency.
// Build option: define IMAGE_STREAM_ARBITER_TLAST_EN to add the m_tlast output.
module image_stream_arbiter
    import image_arb_pkg::*;
#(
    parameter int N_SOURCES       = 2,
    parameter int WORDS_PER_IMAGE = 4,
    parameter int BITS_PER_WORD   = 8,
    localparam int DW = 8 * ((BITS_PER_WORD + 7) / 8),
    localparam int SW = src_width(N_SOURCES)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [N_SOURCES*DW-1:0] s_tdata,
    input  logic [N_SOURCES-1:0]    s_tvalid,
    output logic [N_SOURCES-1:0]    s_tready,
    output logic [DW-1:0]           m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [SW-1:0]           m_tdest
`ifdef IMAGE_STREAM_ARBITER_TLAST_EN
    ,
    output logic                    m_tlast
`endif
);

    localparam int          CW       = $clog2(WORDS_PER_IMAGE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_IMAGE - 1);

    state_e        state_q;
    logic [SW-1:0] grant_q;
    logic [SW-1:0] last_q;
    logic [CW-1:0] cnt_q;

    logic          pick_found;
    logic [SW-1:0] pick_idx;
    logic          handshake;

    image_rr_pick #(
        .N  (N_SOURCES),
        .SW (SW)
    ) u_pick (
        .req   (s_tvalid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Pass-through of the granted source; everything is closed off in IDLE.
    always_comb begin
        m_tvalid = 1'b0;
        s_tready = '0;
        m_tdata  = s_tdata[int'(grant_q)*DW +: DW];
        m_tdest  = grant_q;
        if (state_q == STREAM) begin
            m_tvalid          = s_tvalid[grant_q];
            s_tready[grant_q] = m_tready;
        end
    end

    assign handshake = m_tvalid && m_tready;

    // last_q resets to the top index so the first search starts at source 0.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= SW'(N_SOURCES - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        last_q  <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IMAGE_STREAM_ARBITER_TLAST_EN
    assign m_tlast = (state_q == STREAM) && (cnt_q == CNT_LAST);
`endif

endmodule

// File: tb/tb_image_stream_arbiter.sv
// Directed bench for image_stream_arbiter.
// u_dut0: N_SOURCES=2, WORDS_PER_IMAGE=4 (single image, alternation, sink stalls,
//         source stalls, mid-image reset).
// u_dut1: N_SOURCES=2, WORDS_PER_IMAGE=1 (one-word images, dest/tlast scoreboard).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_image_stream_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int SW = 1;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;

    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [SW-1:0]   m_tdest;

    logic [N*DW-1:0] b_s_tdata;
    logic [N-1:0]    b_s_tvalid;
    logic [N-1:0]    b_s_tready;
    logic [DW-1:0]   b_m_tdata;
    logic            b_m_tvalid;
    logic            b_m_tready;
    logic [SW-1:0]   b_m_tdest;

`ifdef IMAGE_STREAM_ARBITER_TLAST_EN
    logic            m_tlast;
    logic            b_m_tlast;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int word_n [N];   // source-side word counters (advance on real handshakes)
    int exp_n  [N];   // expected word index per source
    logic [N-1:0] hs;

    logic [DW-1:0] exp_q[$];

    always #5 ap_clk = ~ap_clk;

    image_stream_arbiter #(
        .N_SOURCES       (2),
        .WORDS_PER_IMAGE (4),
        .BITS_PER_WORD   (8)
    ) u_dut0 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdest  (m_tdest)
`ifdef IMAGE_STREAM_ARBITER_TLAST_EN
        ,
        .m_tlast  (m_tlast)
`endif
    );

    image_stream_arbiter #(
        .N_SOURCES       (2),
        .WORDS_PER_IMAGE (1),
        .BITS_PER_WORD   (8)
    ) u_dut1 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_tdata  (b_s_tdata),
        .s_tvalid (b_s_tvalid),
        .s_tready (b_s_tready),
        .m_tdata  (b_m_tdata),
        .m_tvalid (b_m_tvalid),
        .m_tready (b_m_tready),
        .m_tdest  (b_m_tdest)
`ifdef IMAGE_STREAM_ARBITER_TLAST_EN
        ,
        .m_tlast  (b_m_tlast)
`endif
    );

    function automatic logic [DW-1:0] word_val(input int src, input int n);
        logic [DW-1:0] base;
        base = (src == 0) ? 8'hA0 : 8'hB0;
        return base + DW'(n);
    endfunction

    task automatic drive_data();
        s_tdata = {word_val(1, word_n[1]), word_val(0, word_n[0])};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic vld, input logic [DW-1:0] data,
                              input logic [SW-1:0] dest, input logic [N-1:0] rdy,
                              input logic last);
        #1;
        chk({tag, ".tvalid"}, 32'(m_tvalid), 32'(vld));
        if (vld) chk({tag, ".tdata"}, 32'(m_tdata), 32'(data));
        chk({tag, ".tdest"}, 32'(m_tdest), 32'(dest));
        chk({tag, ".s_tready"}, 32'(s_tready), 32'(rdy));
`ifdef IMAGE_STREAM_ARBITER_TLAST_EN
        chk({tag, ".tlast"}, 32'(m_tlast), 32'(last));
`else
        if (last === 1'bx) $display("note: unknown last flag at %s", tag);
`endif
    endtask

    // Source model: a word is consumed when its source saw valid && ready
    // before the edge; the next word is presented just after the edge.
    task automatic cyc();
        for (int i = 0; i < N; i++) hs[i] = s_tvalid[i] && s_tready[i];
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) word_n[i]++;
        drive_data();
    endtask

    initial begin
        int prev_src;
        int src;
        int cnt;
        logic [DW-1:0] e;

        ap_rst_n   = 1'b0;
        s_tvalid   = '0;
        m_tready   = 1'b0;
        word_n     = '{0, 0};
        exp_n      = '{0, 0};
        hs         = '0;
        drive_data();
        b_s_tdata  = {8'h21, 8'h10};
        b_s_tvalid = '0;
        b_m_tready = 1'b0;

        // Reset state
        expect_out("reset", 1'b0, '0, 1'b0, 2'b00, 1'b0);
        chk("reset.b_tvalid", 32'(b_m_tvalid), 32'd0);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        // Single source, continuous sink
        s_tvalid = 2'b01;
        m_tready = 1'b1;
        expect_out("t1.idle", 1'b0, '0, 1'b0, 2'b00, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("t1.w%0d", k), 1'b1, word_val(0, exp_n[0]), 1'b0, 2'b01, k == 3);
            exp_n[0]++;
            cyc();
        end
        prev_src = 0;

        // Both sources valid: images alternate, s1 first since s0 went last
        s_tvalid = 2'b11;
        for (int img = 0; img < 4; img++) begin
            src = (img % 2 == 0) ? 1 : 0;
            expect_out($sformatf("t2.idle%0d", img), 1'b0, '0, SW'(prev_src), 2'b00, 1'b0);
            cyc();
            for (int k = 0; k < 4; k++) begin
                expect_out($sformatf("t2.i%0d.w%0d", img, k), 1'b1, word_val(src, exp_n[src]),
                           SW'(src), N'(1 << src), k == 3);
                exp_n[src]++;
                cyc();
            end
            prev_src = src;
        end

        // Sink ready toggling 1,0,1,0,... during an s1 image
        s_tvalid = 2'b10;
        expect_out("t3.idle", 1'b0, '0, 1'b0, 2'b00, 1'b0);
        cyc();
        cnt = 0;
        for (int c = 0; c < 7; c++) begin
            m_tready = (c % 2 == 0);
            expect_out($sformatf("t3.c%0d", c), 1'b1, word_val(1, exp_n[1]), 1'b1,
                       {m_tready, 1'b0}, cnt == 3);
            if (m_tready) begin
                exp_n[1]++;
                cnt++;
            end
            cyc();
        end
        m_tready = 1'b1;
        expect_out("t3.done", 1'b0, '0, 1'b1, 2'b00, 1'b0);
        cyc();

        // Granted s1 drops valid after two words while s0 is waiting
        s_tvalid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            expect_out($sformatf("t4.w%0d", k), 1'b1, word_val(1, exp_n[1]), 1'b1, 2'b10, 1'b0);
            exp_n[1]++;
            cyc();
        end
        s_tvalid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            expect_out($sformatf("t4.stall%0d", c), 1'b0, '0, 1'b1, 2'b10, 1'b0);
            cyc();
        end
        s_tvalid = 2'b11;
        for (int k = 2; k < 4; k++) begin
            expect_out($sformatf("t4.w%0d", k), 1'b1, word_val(1, exp_n[1]), 1'b1, 2'b10, k == 3);
            exp_n[1]++;
            cyc();
        end
        s_tvalid = 2'b10;
        expect_out("t4.done", 1'b0, '0, 1'b1, 2'b00, 1'b0);
        cyc();

        // Reset after the first word of an s1 image
        expect_out("t5.w0", 1'b1, word_val(1, exp_n[1]), 1'b1, 2'b10, 1'b0);
        exp_n[1]++;
        cyc();
        ap_rst_n = 1'b0;
        expect_out("t5.rst", 1'b0, '0, 1'b0, 2'b00, 1'b0);
        cyc();
        cyc();
        ap_rst_n = 1'b1;
        s_tvalid = 2'b11;
        expect_out("t5.idle", 1'b0, '0, 1'b0, 2'b00, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("t5.s0w%0d", k), 1'b1, word_val(0, exp_n[0]), 1'b0, 2'b01, k == 3);
            exp_n[0]++;
            cyc();
        end
        s_tvalid = 2'b00;
        expect_out("t5.done", 1'b0, '0, 1'b0, 2'b00, 1'b0);

        // One-word images: strict alternation with a bubble between words
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        b_s_tvalid = 2'b11;
        b_m_tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c % 2 == 0) begin
                chk($sformatf("t6.c%0d.bubble", c), 32'(b_m_tvalid), 32'd0);
                chk($sformatf("t6.c%0d.b_rdy", c), 32'(b_s_tready), 32'd0);
            end else begin
                chk($sformatf("t6.c%0d.tvalid", c), 32'(b_m_tvalid), 32'd1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                chk($sformatf("t6.c%0d.tdest", c), 32'(b_m_tdest), 32'(e));
                chk($sformatf("t6.c%0d.tdata", c), 32'(b_m_tdata), (e == 0) ? 32'h10 : 32'h21);
                chk($sformatf("t6.c%0d.b_rdy", c), 32'(b_s_tready), (e == 0) ? 32'd1 : 32'd2);
`ifdef IMAGE_STREAM_ARBITER_TLAST_EN
                chk($sformatf("t6.c%0d.tlast", c), 32'(b_m_tlast), 32'd1);
`endif
            end
            @(posedge ap_clk);
            #1;
        end
        b_s_tvalid = 2'b00;
        chk("t6.queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
